// File: rtl/virtual_ds2431_mem_read_scratchpad_pkg.sv
// Shared definitions for the DS2431 Read Scratchpad (0xAA) command stage.
// Optional build macro VDS2431_RDSP_FF_PAD_EN enables the 0xFF padding state.
package virtual_ds2431_mem_read_scratchpad_pkg;

   localparam logic [7:0]  RDSP_OPCODE = 8'hAA;
   localparam logic [15:0] CRC16_POLY  = 16'hA001;
   localparam logic [15:0] CRC16_INIT  = 16'h0000;

   localparam int ES_AA_BIT = 7;
   localparam int ES_PF_BIT = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_DONE,
      ST_PAD
   } rdsp_state_t;

endpackage

// File: rtl/virtual_ds2431_mem_read_scratchpad_crc16.sv
// Combinational byte-wide CRC16 update (reflected 0xA001, LSB first).
// Shared by the write-, read- and copy-scratchpad command stages.
module virtual_ds2431_crc16_byte
   import virtual_ds2431_mem_read_scratchpad_pkg::*;
(
   input  logic [15:0] crcIn,
   input  logic [7:0]  dat,
   output logic [15:0] crcOut
);

   always_comb begin
      logic [15:0] c;
      c = crcIn ^ {8'h00, dat};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
      end
      crcOut = c;
   end

endmodule

// File: rtl/virtual_ds2431_mem_read_scratchpad.sv
// DS2431 Read Scratchpad: streams TA1, TA2, E/S, scratchpad bytes and inverted CRC16.
// Build macro VDS2431_RDSP_FF_PAD_EN keeps answering read slots with 0xFF after the CRC.
module virtual_ds2431_mem_read_scratchpad
   import virtual_ds2431_mem_read_scratchpad_pkg::*;
(
   input  logic        clk,
   input  logic        nRst,
   input  logic        cmdRunTrig,
   input  logic        endCmd,
   input  logic [7:0]  TA1,
   input  logic [7:0]  TA2,
   input  logic [2:0]  ES,
   input  logic        PF,
   input  logic        AA,
   input  logic [63:0] Scratchpad,
   input  logic        ByteTransDone,
   output logic [7:0]  sentDat,
   output logic        transTrig,
   output logic        nRxTx,
   output logic        cmdDone,
   output logic        cmdFailed
);

   rdsp_state_t state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [15:0] crc_q, crc_d;
   logic [7:0]  ta1_q, ta1_d, ta2_q, ta2_d, es_q, es_d;
   logic [63:0] sp_q, sp_d;
   logic        fail_q, fail_d;
`ifdef VDS2431_RDSP_FF_PAD_EN
   logic        pad_trig_q, pad_trig_d;
`endif

   logic [3:0]  data_end;
   logic        is_crc, is_crc_hi;
   logic [7:0]  es_byte, cur_byte, crc_dat;
   logic [15:0] crc_in, crc_out;

   virtual_ds2431_crc16_byte u_crc (
      .crcIn  (crc_in),
      .dat    (crc_dat),
      .crcOut (crc_out)
   );

   // Last data byte index depends on the start offset: 3 header bytes plus 8-TA1[2:0] data bytes.
   always_comb begin
      data_end  = 4'd10 - {1'b0, ta1_q[2:0]};
      is_crc    = idx_q > data_end;
      is_crc_hi = idx_q == (data_end + 4'd2);

      es_byte            = 8'h00;
      es_byte[2:0]       = ES;
      es_byte[ES_PF_BIT] = PF;
      es_byte[ES_AA_BIT] = AA;

      if (idx_q == 4'd0)              cur_byte = ta1_q;
      else if (idx_q == 4'd1)         cur_byte = ta2_q;
      else if (idx_q == 4'd2)         cur_byte = es_q;
      else if (idx_q <= data_end)     cur_byte = sp_q[{ptr_q, 3'b000} +: 8];
      else if (idx_q == data_end + 4'd1) cur_byte = ~crc_q[7:0];
      else                            cur_byte = ~crc_q[15:8];

      // In IDLE the single CRC instance computes the opcode seed.
      crc_in  = (state_q == ST_IDLE) ? CRC16_INIT  : crc_q;
      crc_dat = (state_q == ST_IDLE) ? RDSP_OPCODE : cur_byte;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      crc_d     = crc_q;
      ta1_d     = ta1_q;
      ta2_d     = ta2_q;
      es_d      = es_q;
      sp_d      = sp_q;
      fail_d    = 1'b0;
`ifdef VDS2431_RDSP_FF_PAD_EN
      pad_trig_d = 1'b0;
`endif
      sentDat   = 8'hFF;
      transTrig = 1'b0;
      nRxTx     = 1'b0;
      cmdDone   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmdRunTrig && !endCmd) begin
               ta1_d   = TA1;
               ta2_d   = TA2;
               es_d    = es_byte;
               sp_d    = Scratchpad;
               crc_d   = crc_out;
               idx_d   = 4'd0;
               ptr_d   = TA1[2:0];
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            sentDat   = cur_byte;
            transTrig = 1'b1;
            nRxTx     = 1'b1;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            sentDat = cur_byte;
            nRxTx   = 1'b1;
            if (ByteTransDone) begin
               if (!is_crc) crc_d = crc_out;
               if (idx_q > 4'd2 && !is_crc) ptr_d = ptr_q + 3'd1;
               idx_d   = idx_q + 4'd1;
               state_d = is_crc_hi ? ST_DONE : ST_SEND;
            end
         end
         ST_DONE: begin
            cmdDone = 1'b1;
            nRxTx   = 1'b1;
`ifdef VDS2431_RDSP_FF_PAD_EN
            state_d = ST_PAD;
`else
            state_d = ST_IDLE;
`endif
         end
         ST_PAD: begin
`ifdef VDS2431_RDSP_FF_PAD_EN
            nRxTx      = 1'b1;
            transTrig  = pad_trig_q;
            pad_trig_d = ByteTransDone;
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort only counts as a failure while CRC bytes are still outstanding.
      if (endCmd && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         fail_d  = (state_q == ST_SEND) || (state_q == ST_WAIT);
`ifdef VDS2431_RDSP_FF_PAD_EN
         pad_trig_d = 1'b0;
`endif
      end
   end

   assign cmdFailed = fail_q;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= ST_IDLE;
         idx_q   <= 4'd0;
         ptr_q   <= 3'd0;
         crc_q   <= CRC16_INIT;
         ta1_q   <= 8'h00;
         ta2_q   <= 8'h00;
         es_q    <= 8'h00;
         sp_q    <= 64'h0;
         fail_q  <= 1'b0;
`ifdef VDS2431_RDSP_FF_PAD_EN
         pad_trig_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         crc_q   <= crc_d;
         ta1_q   <= ta1_d;
         ta2_q   <= ta2_d;
         es_q    <= es_d;
         sp_q    <= sp_d;
         fail_q  <= fail_d;
`ifdef VDS2431_RDSP_FF_PAD_EN
         pad_trig_q <= pad_trig_d;
`endif
      end
   end

endmodule

// File: tb/tb_virtual_ds2431_mem_read_scratchpad.sv
// Scoreboard bench for the Read Scratchpad stage: expected bytes are queued when a
// command is issued and popped as the DUT raises transTrig.
module tb_virtual_ds2431_mem_read_scratchpad;

   logic        clk = 1'b0;
   logic        nRst;
   logic        cmdRunTrig;
   logic        endCmd;
   logic [7:0]  TA1;
   logic [7:0]  TA2;
   logic [2:0]  ES;
   logic        PF;
   logic        AA;
   logic [63:0] Scratchpad;
   logic        ByteTransDone;
   logic [7:0]  sentDat;
   logic        transTrig;
   logic        nRxTx;
   logic        cmdDone;
   logic        cmdFailed;

   int errors = 0;
   int checks = 0;
   int trigTotal = 0;
   int doneTotal = 0;
   int failTotal = 0;
   logic [7:0] expQ[$];

   virtual_ds2431_mem_read_scratchpad dut (
      .clk           (clk),
      .nRst          (nRst),
      .cmdRunTrig    (cmdRunTrig),
      .endCmd        (endCmd),
      .TA1           (TA1),
      .TA2           (TA2),
      .ES            (ES),
      .PF            (PF),
      .AA            (AA),
      .Scratchpad    (Scratchpad),
      .ByteTransDone (ByteTransDone),
      .sentDat       (sentDat),
      .transTrig     (transTrig),
      .nRxTx         (nRxTx),
      .cmdDone       (cmdDone),
      .cmdFailed     (cmdFailed)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the active edge so the main thread can read them at negedge without races
   always @(posedge clk) begin
      if (transTrig) trigTotal++;
      if (cmdDone)   doneTotal++;
      if (cmdFailed) failTotal++;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      checks++;
      if (got !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, expected, $time);
      end
   endtask

   // Bit-serial reference CRC16 (x^16+x^15+x^2+1, reflected)
   function automatic logic [15:0] crcModel(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ d[i];
         r  = r >> 1;
         if (fb) r = r ^ 16'hA001;
      end
      return r;
   endfunction

   task automatic pushByte(input logic [7:0] b, inout logic [15:0] crc);
      expQ.push_back(b);
      crc = crcModel(crc, b);
   endtask

   task automatic buildExpected(input logic [7:0] ta1, input logic [7:0] ta2, input logic [2:0] es,
                                input logic pf, input logic aa, input logic [63:0] sp);
      logic [15:0] crc;
      crc = crcModel(16'h0000, 8'hAA);
      pushByte(ta1, crc);
      pushByte(ta2, crc);
      pushByte({aa, 1'b0, pf, 2'b00, es}, crc);
      for (int k = int'(ta1[2:0]); k < 8; k++) pushByte(sp[8*k +: 8], crc);
      expQ.push_back(~crc[7:0]);
      expQ.push_back(~crc[15:8]);
   endtask

   // Issue the command and then scramble the inputs to prove they were latched
   task automatic applyStimulus(input logic [7:0] ta1, input logic [7:0] ta2, input logic [2:0] es,
                                input logic pf, input logic aa, input logic [63:0] sp);
      TA1 = ta1; TA2 = ta2; ES = es; PF = pf; AA = aa; Scratchpad = sp;
      cmdRunTrig = 1'b1;
      buildExpected(ta1, ta2, es, pf, aa, sp);
      @(negedge clk);
      cmdRunTrig = 1'b0;
      checkOutput("startLatency", 32'(transTrig), 32'd1);
      TA1 = ~ta1; TA2 = ~ta2; ES = ~es; PF = ~pf; AA = ~aa; Scratchpad = ~sp;
   endtask

   // Transceiver model: acknowledges each byte; optional abort together with the Nth acknowledge
   task automatic serviceBytes(input int nBytes, input int abortAt, input bit retrig);
      int w;
      logic [7:0] expByte;
      for (int b = 1; b <= nBytes; b++) begin
         w = 0;
         while (!transTrig && w < 40) begin
            @(negedge clk);
            w++;
         end
         if (!transTrig) begin
            checkOutput("trigTimeout", 32'(transTrig), 32'd1);
            return;
         end
         expByte = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
         checkOutput("sentDat", 32'(sentDat), 32'(expByte));
         checkOutput("nRxTxTx", 32'(nRxTx), 32'd1);
         @(negedge clk);
         checkOutput("trigPulse", 32'(transTrig), 32'd0);
         if (retrig) cmdRunTrig = 1'b1;
         @(negedge clk);
         cmdRunTrig = 1'b0;
         checkOutput("sentDatHold", 32'(sentDat), 32'(expByte));
         ByteTransDone = 1'b1;
         if (b == abortAt) endCmd = 1'b1;
         @(negedge clk);
         ByteTransDone = 1'b0;
         endCmd        = 1'b0;
         if (b == abortAt) return;
      end
   endtask

   task automatic runFull(input logic [7:0] ta1, input logic [7:0] ta2, input logic [2:0] es,
                          input logic pf, input logic aa, input logic [63:0] sp, input bit retrig);
      int tBase, dBase, nExp, padExtra;
      tBase    = trigTotal;
      dBase    = doneTotal;
      padExtra = 0;
      applyStimulus(ta1, ta2, es, pf, aa, sp);
      nExp = expQ.size();
      serviceBytes(nExp, 0, retrig);
      checkOutput("cmdDone", 32'(cmdDone), 32'd1);
      checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
`ifdef VDS2431_RDSP_FF_PAD_EN
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ByteTransDone = 1'b1;
         @(negedge clk);
         ByteTransDone = 1'b0;
         checkOutput("padTrig", 32'(transTrig), 32'd1);
         checkOutput("padDat", 32'(sentDat), 32'hFF);
         checkOutput("padDir", 32'(nRxTx), 32'd1);
      end
      padExtra = 3;
      endCmd = 1'b1;
      @(negedge clk);
      endCmd = 1'b0;
      checkOutput("padEndFailed", 32'(cmdFailed), 32'd0);
      checkOutput("padEndDir", 32'(nRxTx), 32'd0);
`else
      @(negedge clk);
      checkOutput("cmdDonePulse", 32'(cmdDone), 32'd0);
      checkOutput("idleDir", 32'(nRxTx), 32'd0);
      for (int k = 0; k < 2; k++) begin
         ByteTransDone = 1'b1;
         @(negedge clk);
         ByteTransDone = 1'b0;
         @(negedge clk);
      end
`endif
      repeat (6) @(negedge clk);
      checkOutput("trigCount", 32'(trigTotal - tBase), 32'(nExp + padExtra));
      checkOutput("doneCount", 32'(doneTotal - dBase), 32'd1);
   endtask

   initial begin
      logic [63:0] sp;
      int tBase, dBase, fBase;

      nRst = 1'b0; cmdRunTrig = 1'b0; endCmd = 1'b0; ByteTransDone = 1'b0;
      TA1 = 8'h00; TA2 = 8'h00; ES = 3'b000; PF = 1'b0; AA = 1'b0; Scratchpad = 64'h0;
      repeat (3) @(negedge clk);
      checkOutput("rstSentDat", 32'(sentDat), 32'hFF);
      checkOutput("rstTrig", 32'(transTrig), 32'd0);
      checkOutput("rstDir", 32'(nRxTx), 32'd0);
      checkOutput("rstDone", 32'(cmdDone), 32'd0);
      checkOutput("rstFailed", 32'(cmdFailed), 32'd0);
      nRst = 1'b1;
      @(negedge clk);

      $display("[TB] full read from offset 0");
      for (int i = 0; i < 8; i++) sp[8*i +: 8] = 8'(i);
      runFull(8'h00, 8'h00, 3'b111, 1'b0, 1'b0, sp, 1'b0);

      $display("[TB] read from offset 6 with PF and AA");
      runFull(8'h06, 8'h00, 3'b111, 1'b1, 1'b1, sp, 1'b0);

      $display("[TB] abort with the third acknowledge");
      tBase = trigTotal; dBase = doneTotal; fBase = failTotal;
      sp = {$urandom, $urandom};
      applyStimulus(8'h03, 8'h12, 3'b010, 1'b0, 1'b1, sp);
      serviceBytes(expQ.size(), 3, 1'b0);
      checkOutput("abortFailed", 32'(cmdFailed), 32'd1);
      checkOutput("abortDir", 32'(nRxTx), 32'd0);
      checkOutput("abortTrig", 32'(transTrig), 32'd0);
      checkOutput("abortDat", 32'(sentDat), 32'hFF);
      @(negedge clk);
      checkOutput("abortFailedPulse", 32'(cmdFailed), 32'd0);
      repeat (8) @(negedge clk);
      checkOutput("abortTrigCount", 32'(trigTotal - tBase), 32'd3);
      checkOutput("abortDoneCount", 32'(doneTotal - dBase), 32'd0);
      checkOutput("abortFailCount", 32'(failTotal - fBase), 32'd1);
      expQ.delete();

      $display("[TB] cmdRunTrig repeated while busy");
      sp = {$urandom, $urandom};
      runFull(8'h25, 8'h01, 3'b101, 1'b0, 1'b0, sp, 1'b1);

      $display("[TB] asynchronous reset mid-transfer");
      sp = {$urandom, $urandom};
      applyStimulus(8'h01, 8'h00, 3'b111, 1'b1, 1'b0, sp);
      serviceBytes(4, 0, 1'b0);
      @(negedge clk);
      #2 nRst = 1'b0;
      #1;
      checkOutput("midRstSentDat", 32'(sentDat), 32'hFF);
      checkOutput("midRstTrig", 32'(transTrig), 32'd0);
      checkOutput("midRstDir", 32'(nRxTx), 32'd0);
      checkOutput("midRstDone", 32'(cmdDone), 32'd0);
      checkOutput("midRstFailed", 32'(cmdFailed), 32'd0);
      @(negedge clk);
      nRst = 1'b1;
      expQ.delete();
      @(negedge clk);
      sp = {$urandom, $urandom};
      runFull(8'h02, 8'h7F, 3'b111, 1'b0, 1'b1, sp, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
